// File: rtl/secp256k1_add_mod_arbiter_if.sv
// Bundle between the requesters, the add-mod arbiter and the shared adder.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding environment, which drives requests and hosts the adder.
interface secp256k1_add_mod_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 256
);
    // requester side
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_error;
    logic                     busy;

    // adder side
    logic                     add_start;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic [WIDTH-1:0]         add_result;
    logic                     add_done;

    modport slave (
        input  req_valid, req_a, req_b, add_result, add_done,
        output req_ready, rsp_valid, rsp_result, rsp_error, busy,
               add_start, add_a, add_b
    );

    modport master (
        output req_valid, req_a, req_b, add_result, add_done,
        input  req_ready, rsp_valid, rsp_result, rsp_error, busy,
               add_start, add_a, add_b
    );
endinterface

// File: rtl/secp256k1_add_mod_arbiter.sv
// Round-robin arbiter that shares one secp256k1 modular adder among
// NUM_REQ requesters. It captures the winner's operands, issues a one-cycle
// start, waits for done under a watchdog and routes the response back to
// the winner. All outputs come straight from registers.
//
// state | meaning
// IDLE  | no transaction; a grant is made when any req_valid is set
// ISSUE | one cycle; req_ready and add_start are high for the winner
// WAIT  | waiting for add_done; the watchdog aborts after TIMEOUT cycles
module secp256k1_add_mod_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 256,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    secp256k1_add_mod_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [IDX_W-1:0]   rr_ptr_q,     rr_ptr_d;
    logic [IDX_W-1:0]   gnt_q,        gnt_d;
    logic [WD_W-1:0]    wd_cnt_q,     wd_cnt_d;
    logic [NUM_REQ-1:0] req_ready_q,  req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_q,  rsp_valid_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_error_q,  rsp_error_d;
    logic               busy_q,       busy_d;
    logic               add_start_q,  add_start_d;
    logic [WIDTH-1:0]   add_a_q,      add_a_d;
    logic [WIDTH-1:0]   add_b_q,      add_b_d;

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;

    // Round-robin search: first asserted request after the last winner, with wrap.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(rr_ptr_q) + off) % NUM_REQ;
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    // Next-state and registered-output logic for the grant/issue/wait sequence.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        wd_cnt_d     = wd_cnt_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = 1'b0;
        add_start_d  = 1'b0;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    gnt_d       = grant_idx;
                    rr_ptr_d    = grant_idx;
                    add_a_d     = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
                    add_b_d     = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
                    req_ready_d = NUM_REQ'(1) << grant_idx;
                    add_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.add_done) begin
                    rsp_result_d = bus.add_result;
                    rsp_valid_d  = NUM_REQ'(1) << gnt_q;
                    state_d      = ST_IDLE;
                end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
                    // adder never answered: report an abort to the winner
                    rsp_result_d = '0;
                    rsp_valid_d  = NUM_REQ'(1) << gnt_q;
                    rsp_error_d  = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
            gnt_q        <= '0;
            wd_cnt_q     <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
            busy_q       <= 1'b0;
            add_start_q  <= 1'b0;
            add_a_q      <= '0;
            add_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            wd_cnt_q     <= wd_cnt_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            busy_q       <= busy_d;
            add_start_q  <= add_start_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_error  = rsp_error_q;
    assign bus.busy       = busy_q;
    assign bus.add_start  = add_start_q;
    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;

endmodule

// File: tb/tb_secp256k1_add_mod_arbiter.sv
// Bench for the shared add-mod arbiter. A behavioural adder stub answers
// two cycles after it sees start, which gives the C0..C5 latency. Its done
// output can be disabled so the watchdog path can be exercised.
module tb_secp256k1_add_mod_arbiter;
    localparam int NR = 4;
    localparam int W  = 256;
    localparam int TO = 16;
    localparam logic [W-1:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    secp256k1_add_mod_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    secp256k1_add_mod_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- adder stub ----------------
    logic         stub_en  = 1'b1;
    logic         man_done = 1'b0;
    logic         stub_done;
    logic [1:0]   stub_cnt;
    logic [W-1:0] stub_res;

    function automatic logic [W-1:0] adder_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = ({1'b0, a} + {1'b0, b}) % {1'b0, P};
        return s[W-1:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt  <= 2'd0;
            stub_done <= 1'b0;
            stub_res  <= '0;
        end else begin
            stub_done <= 1'b0;
            if (bus.add_start && stub_en) begin
                stub_cnt <= 2'd2;
            end else if (stub_cnt != 2'd0) begin
                stub_cnt <= stub_cnt - 2'd1;
                if (stub_cnt == 2'd1) begin
                    stub_done <= 1'b1;
                    stub_res  <= adder_fn(bus.add_a, bus.add_b);
                end
            end
        end
    end

    assign bus.add_done   = stub_done | man_done;
    assign bus.add_result = stub_res;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[W-1:0];
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NR-1:0] v);
        for (int off = 1; off <= NR; off++) begin
            if (v[(ptr + off) % NR]) return (ptr + off) % NR;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
        if (v >= P) v = v - P;
        return v;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    logic [W-1:0]  ra [NR];
    logic [W-1:0]  rb [NR];
    int            g_idx [16];
    int            g_cyc [16];
    logic [NR-1:0] r_vec [16];
    int            r_cyc [16];
    logic [W-1:0]  r_res [16];
    logic          r_err [16];
    int            n_g, n_r;

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        ra[i] = a;
        rb[i] = b;
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_valid[i]    = 1'b1;
    endtask

    task automatic reset_dut();
        bus.req_valid = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs until n_rsp responses arrive, dropping each winner's req_valid once it sees req_ready.
    task automatic serve(input int n_rsp, input int budget);
        int k;
        n_g = 0;
        n_r = 0;
        k   = 0;
        while (k < budget && n_r < n_rsp) begin
            @(negedge clk);
            k++;
            if (bus.req_ready != '0) begin
                if (n_g < 16) begin
                    g_cyc[n_g] = cyc;
                    g_idx[n_g] = -1;
                    for (int i = 0; i < NR; i++) if (bus.req_ready[i]) g_idx[n_g] = i;
                    n_g++;
                end
                bus.req_valid = bus.req_valid & ~bus.req_ready;
            end
            if (bus.rsp_valid != '0 && n_r < 16) begin
                r_vec[n_r] = bus.rsp_valid;
                r_cyc[n_r] = cyc;
                r_res[n_r] = bus.rsp_result;
                r_err[n_r] = bus.rsp_error;
                n_r++;
            end
        end
        if (n_r < n_rsp) begin
            errors++;
            $display("FAIL serve_timeout: got %0d responses, expected %0d", n_r, n_rsp);
        end
        checks++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.busy, bus.add_start} !== '0 ||
            bus.rsp_result !== '0 || bus.add_a !== '0 || bus.add_b !== '0) begin
            errors++;
            $display("FAIL reset_values: got ready=%b rsp=%b err=%b busy=%b start=%b, expected all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.busy, bus.add_start);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        set_req(0, 256'd5, 256'd7);
        @(negedge clk);                                   // C1
        checks++;
        if (bus.req_ready !== 4'b0001 || bus.add_start !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got ready=%b start=%b busy=%b, expected 0001 1 1",
                     bus.req_ready, bus.add_start, bus.busy);
        end
        checks++;
        if (bus.add_a !== 256'd5 || bus.add_b !== 256'd7) begin
            errors++;
            $display("FAIL single_operands: got a=%0h b=%0h, expected 5 7", bus.add_a, bus.add_b);
        end
        bus.req_valid = '0;
        @(negedge clk);                                   // C2
        checks++;
        if (bus.req_ready !== '0 || bus.add_start !== 1'b0 || bus.add_a !== 256'd5) begin
            errors++;
            $display("FAIL single_issue_end: got ready=%b start=%b a=%0h, expected 0000 0 5",
                     bus.req_ready, bus.add_start, bus.add_a);
        end
        repeat (2) @(negedge clk);                        // C4
        checks++;
        if (bus.rsp_valid !== '0) begin
            errors++;
            $display("FAIL single_early_rsp: got rsp=%b, expected 0000", bus.rsp_valid);
        end
        @(negedge clk);                                   // C5
        checks++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_result !== 256'd12 || bus.rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: got rsp=%b res=%0h err=%b, expected 0001 c 0",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_error);
        end
        @(negedge clk);                                   // C6
        checks++;
        if (bus.rsp_valid !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp_pulse: got rsp=%b busy=%b, expected 0000 0", bus.rsp_valid, bus.busy);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] pm1;
        pm1 = P - 256'd1;
        set_req(1, pm1, 256'd2);
        serve(1, 40);
        checks++;
        if (r_res[0] !== 256'd1) begin
            errors++;
            $display("FAIL wrap_pm1_plus2: got %0h, expected 1", r_res[0]);
        end
        set_req(1, pm1, pm1);
        serve(1, 40);
        checks++;
        if (r_res[0] !== P - 256'd2) begin
            errors++;
            $display("FAIL wrap_2pm2: got %0h, expected %0h", r_res[0], P - 256'd2);
        end
    endtask

    task automatic test_random();
        int i;
        for (int t = 0; t < 8; t++) begin
            i = int'($urandom_range(0, NR - 1));
            set_req(i, rand_op(), rand_op());
            serve(1, 40);
            checks++;
            if (g_idx[0] !== i || r_vec[0] !== onehot(i) || r_err[0] !== 1'b0 ||
                r_res[0] !== ref_add(ra[i], rb[i]) || r_cyc[0] - g_cyc[0] != 4) begin
                errors++;
                $display("FAIL random_txn: got grant=%0d rsp=%b err=%b lat=%0d res=%0h, expected %0d %b 0 4 %0h",
                         g_idx[0], r_vec[0], r_err[0], r_cyc[0] - g_cyc[0], r_res[0],
                         i, onehot(i), ref_add(ra[i], rb[i]));
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        set_req(2, rand_op(), rand_op());
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);                        // C3, in WAIT
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.busy, bus.add_start} !== '0 ||
            bus.rsp_result !== '0 || bus.add_a !== '0 || bus.add_b !== '0) begin
            errors++;
            $display("FAIL midwait_reset_values: got ready=%b rsp=%b err=%b busy=%b res=%0h a=%0h, expected all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.busy, bus.rsp_result, bus.add_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_r = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) n_r++;
        end
        checks++;
        if (n_r != 0) begin
            errors++;
            $display("FAIL midwait_no_rsp: got %0d responses, expected 0", n_r);
        end
        set_req(0, rand_op(), rand_op());
        set_req(3, rand_op(), rand_op());
        serve(2, 60);
        checks++;
        if (g_idx[0] !== 0 || g_idx[1] !== 3) begin
            errors++;
            $display("FAIL midwait_rr_reset: got order %0d,%0d, expected 0,3", g_idx[0], g_idx[1]);
        end
    endtask

    task automatic test_watchdog();
        int i, c0;
        stub_en = 1'b0;
        i = int'($urandom_range(0, NR - 1));
        set_req(i, rand_op(), rand_op());
        c0 = cyc;
        serve(1, 40);
        checks++;
        if (r_vec[0] !== onehot(i) || r_err[0] !== 1'b1 || r_res[0] !== '0 || r_cyc[0] - c0 != 2 + TO) begin
            errors++;
            $display("FAIL watchdog_abort: got rsp=%b err=%b res=%0h at C%0d, expected %b 1 0 at C%0d",
                     r_vec[0], r_err[0], r_res[0], r_cyc[0] - c0, onehot(i), 2 + TO);
        end
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        n_r = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0 || bus.busy) n_r++;
        end
        checks++;
        if (n_r != 0) begin
            errors++;
            $display("FAIL watchdog_late_done: got %0d active cycles, expected 0", n_r);
        end
        stub_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int c0;
        reset_dut();
        for (int i = 0; i < NR; i++) set_req(i, rand_op(), rand_op());
        c0 = cyc;
        serve(NR, 80);
        for (int k = 0; k < NR; k++) begin
            checks++;
            if (g_idx[k] !== k || r_vec[k] !== onehot(k) || r_cyc[k] - c0 != 5 * (k + 1) ||
                r_err[k] !== 1'b0 || r_res[k] !== ref_add(ra[k], rb[k])) begin
                errors++;
                $display("FAIL b2b_txn%0d: got grant=%0d rsp=%b at C%0d res=%0h, expected %0d %b C%0d %0h",
                         k, g_idx[k], r_vec[k], r_cyc[k] - c0, r_res[k],
                         k, onehot(k), 5 * (k + 1), ref_add(ra[k], rb[k]));
            end
        end
    endtask

    task automatic test_fairness();
        int ptr, exp_g;
        logic [NR-1:0] pend;
        reset_dut();
        set_req(2, rand_op(), rand_op());
        serve(1, 40);
        set_req(0, rand_op(), rand_op());
        set_req(1, rand_op(), rand_op());
        set_req(3, rand_op(), rand_op());
        serve(3, 80);
        ptr  = 2;
        pend = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            exp_g = rr_pick(ptr, pend);
            pend[exp_g] = 1'b0;
            ptr = exp_g;
            checks++;
            if (g_idx[k] !== exp_g || r_vec[k] !== onehot(exp_g) || r_res[k] !== ref_add(ra[exp_g], rb[exp_g])) begin
                errors++;
                $display("FAIL fair_order%0d: got grant=%0d rsp=%b, expected %0d %b",
                         k, g_idx[k], r_vec[k], exp_g, onehot(exp_g));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_random();
        test_reset_mid_wait();
        test_watchdog();
        test_back_to_back();
        test_fairness();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/secp256k1_add_mod_arbiter.md
Name: secp256k1_add_mod_arbiter

Overview:
- Shares one secp256k1_add_mod instance (start/done, 256-bit operands, r = (a+b) mod p) among NUM_REQ requesters, e.g. point-add/double sequencers.
- Round-robin arbitration, operand capture, single-cycle start issue, wait for the done pulse, response routing back to the winner.
- A watchdog aborts a transaction when the adder never returns done.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 256, operand/result width in bits
TIMEOUT, 16, max cycles spent in WAIT before abort (>=4)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester request; held with operands until req_ready seen
req_a  input  NUM_REQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  operand b, same packing
req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse
rsp_valid  output  NUM_REQ  one-hot, one-cycle response pulse
rsp_result  output  WIDTH  result, valid when any rsp_valid bit is high
rsp_error  output  1  qualifies rsp_valid: 1 = watchdog abort
busy  output  1  high whenever state != IDLE
add_start  output  1  to adder start
add_a  output  WIDTH  to adder a
add_b  output  WIDTH  to adder b
add_result  input  WIDTH  from adder result
add_done  input  1  from adder done

Behaviour:
- All outputs are registered. Reset values: req_ready=0, rsp_valid=0, rsp_result=0, rsp_error=0, busy=0, add_start=0, add_a=0, add_b=0. State=IDLE, rr_ptr=NUM_REQ-1, wd_cnt=0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If req_valid != 0, the grant g is the first set bit searching from (rr_ptr+1) mod NUM_REQ upward with wrap.
  - At the clock edge: latch req_a[g]/req_b[g] into add_a/add_b; rr_ptr<=g; req_ready[g]<=1; add_start<=1; go to ISSUE.
  - If req_valid == 0: stay in IDLE, nothing changes.
- ISSUE, lasts exactly 1 cycle: req_ready and add_start are high during this cycle. At its edge both clear, wd_cnt<=0, go to WAIT.
- add_a/add_b hold stable from ISSUE until the next grant.
- WAIT:
  - add_done=1: rsp_result<=add_result, rsp_valid[g]<=1, rsp_error<=0, go to IDLE.
  - Else if wd_cnt==TIMEOUT-1: rsp_result<=0, rsp_valid[g]<=1, rsp_error<=1, go to IDLE.
  - Else: wd_cnt increments.
- rsp_valid and rsp_error are high for exactly one cycle, the first IDLE cycle. A new grant may be made in that same cycle (back-to-back).
- Latency with the standard adder: req_valid first seen in C0 -> req_ready and add_start in C1 -> adder done in C4 -> rsp_valid in C5. Next start at the earliest in C6.
- add_done in IDLE or ISSUE (stray, or late after a timeout) is ignored.
- req_valid dropping after the grant edge has no effect. The transaction completes and the response still goes to g.
- Requesters must not rely on req_ready in the grant cycle itself. They see it the following cycle and drop or refresh req_valid after it.
- A requester holding req_valid continuously is re-granted only after every other asserted requester has been served once.
- Arithmetic is fully delegated to the adder; the arbiter does no modular math. Widths pass through unchanged.
- rst_n asserted mid-transaction (any state): immediate return to reset values. The in-flight request is dropped with no rsp_valid. The adder shares rst_n and is reset too.

Test Plan:
- Single request: req0 a=5, b=7 in C0 -> req_ready=4'b0001 in C1, add_start in C1 only, rsp_valid=4'b0001 with rsp_result=12, rsp_error=0 in C5.
- Modular wrap: a=p-1 (…FFFEFFFFFC2E), b=2 -> rsp_result=1; a=b=p-1 -> rsp_result=p-2.
- Contention: all four req_valid high from reset, each deasserting after its req_ready -> grant order 0,1,2,3; responses in C5, C10, C15, C20; each result routed only to its own rsp_valid bit.
- Fairness: after serving req2, req0 and req3 both valid -> req3 granted first, then req0; a persistent req1 alongside req0/req3 is served in order 3,0,1.
- Watchdog: adder stub never asserts done, TIMEOUT=16 -> rsp_valid for the winner with rsp_error=1 and result 0, 16 cycles after entering WAIT. A late add_done pulse afterwards produces no response.
- Reset mid-WAIT: rst_n low for 1 cycle during WAIT -> all outputs 0 immediately, no rsp_valid. The next request is granted to requester 0 first (rr_ptr reset).
